// File: rtl/alu_exec_unit.sv
// RV32I execute stage: ALU-control decode (Opcode/FuncCode -> 7-bit ALUCtl) merged with the
// 32-bit ALU and branch comparator, result and branch flag registered once.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  Opcode,
    input  logic [3:0]  FuncCode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUOut,
    output logic        Branch_Enable
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [6:0] {
        CTL_ZERO  = 7'h00,
        CTL_ADD   = 7'h01,
        CTL_SUB   = 7'h02,
        CTL_SLL   = 7'h03,
        CTL_SLT   = 7'h04,
        CTL_SLTU  = 7'h05,
        CTL_XOR   = 7'h06,
        CTL_SRL   = 7'h07,
        CTL_SRA   = 7'h08,
        CTL_OR    = 7'h09,
        CTL_AND   = 7'h0A,
        CTL_PASSB = 7'h0B
    } alu_ctl_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6
    } br_sel_e;

    alu_ctl_e    alu_ctl;
    br_sel_e     br_sel;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        br_taken;
    logic        eq, lt, ltu;

    logic [31:0] aluout_d, aluout_q;
    logic        br_d, br_q;

    assign funct3   = FuncCode[2:0];
    assign funct7b5 = FuncCode[3];
    assign shamt    = B[4:0];

    // R-type and I-type share one f3 table; only f3=000 differs (I-type never subtracts).
    always_comb begin
        alu_ctl = CTL_ZERO;
        br_sel  = BR_NONE;
        case (Opcode)
            OPC_OP, OPC_OP_IMM: begin
                case (funct3)
                    3'b000: alu_ctl = (Opcode == OPC_OP && funct7b5) ? CTL_SUB : CTL_ADD;
                    3'b001: alu_ctl = CTL_SLL;
                    3'b010: alu_ctl = CTL_SLT;
                    3'b011: alu_ctl = CTL_SLTU;
                    3'b100: alu_ctl = CTL_XOR;
                    3'b101: alu_ctl = funct7b5 ? CTL_SRA : CTL_SRL;
                    3'b110: alu_ctl = CTL_OR;
                    default: alu_ctl = CTL_AND;
                endcase
            end
            OPC_LUI: alu_ctl = CTL_PASSB;
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: alu_ctl = CTL_ADD;
            OPC_BRANCH: begin
                alu_ctl = CTL_SUB;
                case (funct3)
                    3'b000:  br_sel = BR_EQ;
                    3'b001:  br_sel = BR_NE;
                    3'b100:  br_sel = BR_LT;
                    3'b101:  br_sel = BR_GE;
                    3'b110:  br_sel = BR_LTU;
                    3'b111:  br_sel = BR_GEU;
                    default: br_sel = BR_NONE;
                endcase
            end
            default: begin
                alu_ctl = CTL_ZERO;
                br_sel  = BR_NONE;
            end
        endcase
    end

    assign eq  = (A == B);
    assign lt  = ($signed(A) < $signed(B));
    assign ltu = (A < B);

    always_comb begin
        alu_res = '0;
        case (alu_ctl)
            CTL_ADD:   alu_res = A + B;
            CTL_SUB:   alu_res = A - B;
            CTL_SLL:   alu_res = A << shamt;
            CTL_SLT:   alu_res = {31'd0, lt};
            CTL_SLTU:  alu_res = {31'd0, ltu};
            CTL_XOR:   alu_res = A ^ B;
            CTL_SRL:   alu_res = A >> shamt;
            CTL_SRA:   alu_res = $unsigned($signed(A) >>> shamt);
            CTL_OR:    alu_res = A | B;
            CTL_AND:   alu_res = A & B;
            CTL_PASSB: alu_res = B;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (br_sel)
            BR_EQ:   br_taken = eq;
            BR_NE:   br_taken = !eq;
            BR_LT:   br_taken = lt;
            BR_GE:   br_taken = !lt;
            BR_LTU:  br_taken = ltu;
            BR_GEU:  br_taken = !ltu;
            default: br_taken = 1'b0;
        endcase
    end

    assign aluout_d = alu_res;
    assign br_d     = br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout_q <= '0;
            br_q     <= 1'b0;
        end else begin
            aluout_q <= aluout_d;
            br_q     <= br_d;
        end
    end

    assign ALUOut        = aluout_q;
    assign Branch_Enable = br_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed literal vectors plus an arithmetic reference model
// checked every cycle against the registered outputs.
module tb_alu_exec_unit;

    localparam logic [6:0] R_T = 7'b0110011;
    localparam logic [6:0] I_T = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  Opcode;
    logic [3:0]  FuncCode;
    logic [31:0] A, B;
    logic [31:0] ALUOut;
    logic        Branch_Enable;

    int vectors = 0;
    int miscompares = 0;
    logic        chk_en = 1'b0;
    logic [31:0] exp_out;
    logic        exp_br;

    alu_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .FuncCode(FuncCode),
        .A(A), .B(B), .ALUOut(ALUOut), .Branch_Enable(Branch_Enable)
    );

    always #5 clk = ~clk;

    // Reference: {branch_taken, result} straight from the RV32I instruction semantics.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [3:0] fc,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        t;
        int          sh;
        r  = 32'd0;
        t  = 1'b0;
        sh = int'(b % 32);
        if (op == R_T || op == I_T) begin
            case (fc[2:0])
                3'd0: r = (op == R_T && fc[3]) ? a - b : a + b;
                3'd1: r = a << sh;
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = fc[3] ? $unsigned($signed(a) >>> sh) : a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (op == LUI) begin
            r = b;
        end else if (op == AUI || op == JAL || op == JLR || op == LD || op == ST) begin
            r = a + b;
        end else if (op == BR) begin
            r = a - b;
            case (fc[2:0])
                3'd0: t = (a == b);
                3'd1: t = (a != b);
                3'd4: t = ($signed(a) < $signed(b));
                3'd5: t = ($signed(a) >= $signed(b));
                3'd6: t = (a < b);
                3'd7: t = (a >= b);
                default: t = 1'b0;
            endcase
        end
        return {t, r};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out = 32'd0;
            exp_br  = 1'b0;
        end else begin
            {exp_br, exp_out} = model(Opcode, FuncCode, A, B);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (ALUOut !== exp_out || Branch_Enable !== exp_br) begin
                miscompares++;
                $display("FAIL model: ALUOut=%h Branch_Enable=%b, expected %h/%b",
                         ALUOut, Branch_Enable, exp_out, exp_br);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Called at a falling edge: drive, cross one rising edge, check at the next falling edge.
    task automatic vec(input string name, input logic [6:0] op, input logic [3:0] fc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input bit is_br);
        Opcode = op; FuncCode = fc; A = a; B = b;
        @(negedge clk);
        if (is_br) lit(name, {31'd0, Branch_Enable}, want);
        else       lit(name, ALUOut, want);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [10];
        ops = '{R_T, I_T, LUI, AUI, JAL, JLR, LD, ST, BR, 7'b1111111};
        rst_n = 1'b0; Opcode = R_T; FuncCode = 4'b0000; A = 32'd7; B = 32'd9;
        #2;
        lit("reset_out", ALUOut, 32'd0);
        lit("reset_br", {31'd0, Branch_Enable}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        lit("held_in_reset", ALUOut, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        vec("and",   R_T, 4'b0111, 32'h0F, 32'h55, 32'h05, 0);
        vec("or",    R_T, 4'b0110, 32'h0F, 32'h55, 32'h5F, 0);
        vec("xor",   R_T, 4'b0100, 32'h55, 32'hFF, 32'hAA, 0);
        vec("add",   R_T, 4'b0000, 32'd10000, 32'd111, 32'd10111, 0);
        vec("sub",   R_T, 4'b1000, 32'd10000, 32'd111, 32'd9889, 0);
        vec("addi_f7", I_T, 4'b1000, 32'd10000, 32'd111, 32'd10111, 0);
        vec("slt",   R_T, 4'b0010, 32'd0, 32'd2, 32'd1, 0);
        vec("slt_neg", R_T, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1, 0);
        vec("sltu",  R_T, 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0, 0);
        vec("srl",   R_T, 4'b0101, 32'd16, 32'd2, 32'd4, 0);
        vec("sra",   R_T, 4'b1101, 32'd8, 32'd1, 32'd4, 0);
        vec("sra_neg", R_T, 4'b1101, 32'h80000000, 32'd1, 32'hC0000000, 0);
        vec("srl_neg", R_T, 4'b0101, 32'h80000000, 32'd1, 32'h40000000, 0);
        vec("sll",   R_T, 4'b0001, 32'd2, 32'd2, 32'd8, 0);
        vec("sll16", R_T, 4'b0001, 32'd2, 32'd16, 32'h00020000, 0);
        vec("sll31", R_T, 4'b0001, 32'd1, 32'd31, 32'h80000000, 0);
        vec("sll33", R_T, 4'b0001, 32'd1, 32'd33, 32'd2, 0);
        vec("add_wrap", R_T, 4'b0000, 32'hFFFFFFFF, 32'd2, 32'd1, 0);
        vec("lui",   LUI, 4'b1111, 32'd5, 32'h12345000, 32'h12345000, 0);
        vec("jal",   JAL, 4'b1010, 32'h100, 32'h20, 32'h120, 0);
        vec("br_sub", BR, 4'b0000, 32'd9, 32'd4, 32'd5, 0);
        vec("illegal_op", 7'b1111111, 4'b0000, 32'd9, 32'd4, 32'd0, 0);
        vec("beq",   BR, 4'b0000, 32'd5, 32'd5, 32'd1, 1);
        vec("bne",   BR, 4'b0001, 32'd5, 32'd5, 32'd0, 1);
        vec("blt",   BR, 4'b0100, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
        vec("bltu",  BR, 4'b0110, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
        vec("bge",   BR, 4'b0101, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
        vec("bgeu",  BR, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
        vec("br_f3_010", BR, 4'b0010, 32'd5, 32'd5, 32'd0, 1);
        vec("r_eq_nobr", R_T, 4'b0000, 32'd5, 32'd5, 32'd0, 1);

        // One-cycle latency: new inputs must not show before the next rising edge.
        vec("pre_latency", R_T, 4'b0000, 32'd3, 32'd4, 32'd7, 0);
        Opcode = R_T; FuncCode = 4'b0110; A = 32'hF0; B = 32'h0F;
        #3;
        lit("latency_hold", ALUOut, 32'd7);
        @(negedge clk);
        lit("latency_load", ALUOut, 32'hFF);

        // Asynchronous reset mid-stream, then the first edge after release loads a result.
        Opcode = R_T; FuncCode = 4'b0100; A = 32'h1234; B = 32'h1;
        @(posedge clk);
        #2;
        lit("pre_reset", ALUOut, 32'h1235);
        rst_n = 1'b0;
        #1;
        lit("async_reset_out", ALUOut, 32'd0);
        lit("async_reset_br", {31'd0, Branch_Enable}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vec("after_release", R_T, 4'b0000, 32'd40, 32'd2, 32'd42, 0);

        for (int i = 0; i < 300; i++) begin
            Opcode   = ops[$urandom_range(9)];
            FuncCode = 4'($urandom_range(15));
            A        = (i % 4 == 0) ? B : $urandom;
            B        = (i % 7 == 0) ? 32'($urandom_range(40)) : $urandom;
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
